// File: rtl/cci_mmio_rsp_merge.sv
// cci_mmio_rsp_merge
// Merges CSR-manager and AFU MMIO read responses onto the single c2Tx
// response slot. c2Tx has no back-pressure, so responses that lose the slot
// are parked in a small FIFO and drained one per cycle, oldest first.
// Slot priority: FIFO head, then CSR input, then AFU input.
// Optional statistics: define CCI_MMIO_RSP_MERGE_STATS_EN to build the
// collision counter and the FIFO high-water mark; otherwise both read 0.
module cci_mmio_rsp_merge #(
  parameter int DEPTH     = 8,
  parameter int TID_WIDTH = 9
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       csr_rsp_valid,
  input  logic [TID_WIDTH-1:0]       csr_rsp_tid,
  input  logic [63:0]                csr_rsp_data,
  input  logic                       afu_rsp_valid,
  input  logic [TID_WIDTH-1:0]       afu_rsp_tid,
  input  logic [63:0]                afu_rsp_data,
  output logic                       out_mmioRdValid,
  output logic [TID_WIDTH-1:0]       out_tid,
  output logic [63:0]                out_data,
  output logic                       overflow,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic [31:0]                stat_collisions,
  output logic [$clog2(DEPTH):0]     stat_max_occ
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = TID_WIDTH + 64;

  // FIFO storage, entries are {tid, data}
  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg, count_next;

  logic                 out_valid_reg;
  logic [TID_WIDTH-1:0] out_tid_reg;
  logic [63:0]          out_data_reg;
  logic                 overflow_reg;

  logic                 pop;
  logic                 csr_push_req, afu_push_req;
  logic                 csr_push, afu_push, drop;
  logic [CW-1:0]        space;
  logic [1:0]           push_cnt;
  logic                 slot_a_valid, slot_b_valid;
  logic [EW-1:0]        slot_a_data, slot_b_data;
  logic [EW-1:0]        head;
  logic                 sel_valid;
  logic [EW-1:0]        sel_entry;
  logic [DEPTH-1:0]     we_a, we_b;

  assign head = mem[rd_ptr_reg];

  // Slot arbitration, push acceptance and occupancy bookkeeping
  always_comb begin
    pop          = (count_reg != '0);
    // CSR only loses the slot to the FIFO head; AFU loses to head or CSR
    csr_push_req = csr_rsp_valid && pop;
    afu_push_req = afu_rsp_valid && (pop || csr_rsp_valid);
    // Free entries after this cycle's pop; never exceeds DEPTH since pop implies count>0
    space        = CW'(DEPTH) - count_reg + CW'(pop);
    csr_push     = csr_push_req && (space >= CW'(1));
    afu_push     = afu_push_req && (space >= (CW'(1) + CW'(csr_push)));
    drop         = (csr_push_req && !csr_push) || (afu_push_req && !afu_push);
    push_cnt     = 2'(csr_push) + 2'(afu_push);
    // CSR occupies the first write slot when both push
    slot_a_valid = csr_push || afu_push;
    slot_a_data  = csr_push ? {csr_rsp_tid, csr_rsp_data} : {afu_rsp_tid, afu_rsp_data};
    slot_b_valid = csr_push && afu_push;
    slot_b_data  = {afu_rsp_tid, afu_rsp_data};
    count_next   = count_reg + CW'(push_cnt) - CW'(pop);

    sel_valid = 1'b0;
    sel_entry = head;
    if (pop) begin
      sel_valid = 1'b1;
      sel_entry = head;
    end else if (csr_rsp_valid) begin
      sel_valid = 1'b1;
      sel_entry = {csr_rsp_tid, csr_rsp_data};
    end else if (afu_rsp_valid) begin
      sel_valid = 1'b1;
      sel_entry = {afu_rsp_tid, afu_rsp_data};
    end
  end

  // Per-entry write enables for the two write slots (second slot is wr_ptr+1, wrapping)
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_we
      assign we_a[gi] = slot_a_valid && (wr_ptr_reg == PW'(gi));
      assign we_b[gi] = slot_b_valid && ((wr_ptr_reg + PW'(1)) == PW'(gi));
    end
  endgenerate

  // FIFO storage writes; contents need no reset since pointers define validity
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (we_a[i])
        mem[i] <= slot_a_data;
      else if (we_b[i])
        mem[i] <= slot_b_data;
    end
  end

  // Pointers, occupancy, sticky overflow and registered output slot
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      out_tid_reg   <= '0;
      out_data_reg  <= '0;
    end else begin
      wr_ptr_reg    <= wr_ptr_reg + PW'(push_cnt);
      rd_ptr_reg    <= rd_ptr_reg + PW'(pop);
      count_reg     <= count_next;
      overflow_reg  <= overflow_reg | drop;
      out_valid_reg <= sel_valid;
      if (sel_valid) begin
        out_tid_reg  <= sel_entry[EW-1:64];
        out_data_reg <= sel_entry[63:0];
      end
    end
  end

  assign out_mmioRdValid = out_valid_reg;
  assign out_tid         = out_tid_reg;
  assign out_data        = out_data_reg;
  assign overflow        = overflow_reg;
  assign fifo_count      = count_reg;

`ifdef CCI_MMIO_RSP_MERGE_STATS_EN
  logic [31:0]   stat_collisions_reg;
  logic [CW-1:0] stat_max_occ_reg;

  // Saturating collision counter and occupancy high-water mark
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_collisions_reg <= '0;
      stat_max_occ_reg    <= '0;
    end else begin
      if (slot_a_valid && (stat_collisions_reg != 32'hFFFF_FFFF))
        stat_collisions_reg <= stat_collisions_reg + 32'd1;
      if (count_next > stat_max_occ_reg)
        stat_max_occ_reg <= count_next;
    end
  end

  assign stat_collisions = stat_collisions_reg;
  assign stat_max_occ    = stat_max_occ_reg;
`else
  assign stat_collisions = '0;
  assign stat_max_occ    = '0;
`endif

endmodule

// File: doc/cci_mmio_rsp_merge.md
Name: cci_mmio_rsp_merge

Overview:
- Sits on the MMIO read-response path (c2Tx) between the generic CSR manager and the FIU.
- Merges two MMIO read-response sources into one stream without dropping either: locally generated CSR responses and responses passed through from user AFU code.
- CCI-P c2Tx has no back-pressure, so responses that collide in the same cycle are queued in a small FIFO and drained one per cycle.
- Replaces the "last writer wins" override in the CSR manager.

Parameters:
- DEPTH, 8, FIFO entries for deferred responses; power of 2, minimum 2.
- TID_WIDTH, 9, MMIO transaction ID width (matches t_ccip_tid).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- csr_rsp_valid  in  1  CSR-manager response valid
- csr_rsp_tid  in  TID_WIDTH  CSR-manager response TID
- csr_rsp_data  in  64  CSR-manager response data
- afu_rsp_valid  in  1  AFU response valid
- afu_rsp_tid  in  TID_WIDTH  AFU response TID
- afu_rsp_data  in  64  AFU response data
- out_mmioRdValid  out  1  merged response valid toward the FIU
- out_tid  out  TID_WIDTH  merged response TID
- out_data  out  64  merged response data
- overflow  out  1  sticky: a response was lost because the FIFO was full
- fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy
- stat_collisions  out  32  collision counter (optional feature)
- stat_max_occ  out  $clog2(DEPTH)+1  FIFO high-water mark (optional feature)

Behaviour:
- Reset values: out_mmioRdValid=0, out_tid=0, out_data=0, overflow=0, fifo_count=0, stats=0. FIFO pointers cleared. Entries captured before reset are discarded.
- All outputs are registered. A response presented in cycle N appears on the outputs no earlier than cycle N+1.
- The single output slot is selected each cycle in this priority order:
  1. FIFO head, if the FIFO is non-empty (oldest first).
  2. CSR input.
  3. AFU input.
- Every valid input that does not win the slot is pushed into the FIFO in the same cycle.
  - Push order when both inputs push: CSR first, then AFU.
  - Up to 2 pushes and 1 pop can occur per cycle.
- Occupancy update: fifo_count_next = fifo_count + pushes - pop.
  - A pop is counted only when the FIFO was non-empty at the start of the cycle.
  - Pointers wrap modulo DEPTH.
- Full condition:
  - A push that would take the count beyond DEPTH, after accounting for the same-cycle pop, is dropped.
  - The AFU push is dropped first, then the CSR push.
  - overflow is set and remains set until reset.
- Ordering guarantees:
  - Same-source responses stay in order.
  - Cross-source order within a single cycle is CSR before AFU.
- With no valid inputs and an empty FIFO: out_mmioRdValid=0; out_tid and out_data hold their previous values.
- reset asserted mid-drain: on the next cycle out_mmioRdValid=0 and fifo_count=0. Pending responses are lost by design, since the host times out after reset.

Optional Feature:
- Macro: CCI_MMIO_RSP_MERGE_STATS_EN.
- When defined:
  - stat_collisions increments by 1 in each cycle where at least one response is pushed into the FIFO. It saturates at 0xFFFFFFFF.
  - stat_max_occ records the maximum fifo_count seen since reset.
  - Both are cleared by reset.
- When undefined:
  - Both ports are tied to 0.
  - No counter logic is synthesised.

Test Plan:
- Lone CSR response (tid=0x011, data=0xA5A5) in cycle 0 -> out valid in cycle 1 with tid=0x011, data=0xA5A5; fifo_count stays 0.
- CSR tid=0x001 and AFU tid=0x002 in the same cycle, then idle -> out tid 0x001 in cycle 1, tid 0x002 in cycle 2; fifo_count peaks at 1; stat_collisions=1 (with STATS_EN).
- Both sources valid for 6 consecutive cycles (CSR tids 0x10-0x15, AFU tids 0x20-0x25), DEPTH=8 -> 12 responses out on 12 consecutive cycles with no gaps; output tid order 10,20,11,21,...; overflow=0; stat_max_occ=6.
- Both sources valid for 10 consecutive cycles, DEPTH=8 -> fifo_count reaches 8; the first dropped response is an AFU response; overflow=1 and remains 1; every surviving response emerges exactly once.
- reset asserted while fifo_count=4 -> next cycle out_mmioRdValid=0, fifo_count=0; overflow clears; a CSR response after reset deasserts passes with 1-cycle latency.
- Build without CCI_MMIO_RSP_MERGE_STATS_EN and rerun the collision scenario -> stat_collisions=0 and stat_max_occ=0; functional output is identical.
